// File: rtl/comparator_arbiter.sv
// Round-robin arbiter that shares one unsigned 8-bit comparator between NUM_REQ
// requesters and returns tagged less/equal/greater results on one response channel.

module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       less,
  output logic       equal,
  output logic       greater
);
  assign less    = (a < b);
  assign equal   = (a == b);
  assign greater = (a > b);
endmodule

module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_less,
  output logic                 rsp_equal,
  output logic                 rsp_greater,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0] cur_id_reg, cur_id_next;
  logic [ID_W-1:0] rsp_id_reg, rsp_id_next;
  logic [7:0]      op_a_reg, op_a_next;
  logic [7:0]      op_b_reg, op_b_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic            rsp_less_reg, rsp_less_next;
  logic            rsp_equal_reg, rsp_equal_next;
  logic            rsp_greater_reg, rsp_greater_next;

  logic [7:0]      a_arr [NUM_REQ];
  logic [7:0]      b_arr [NUM_REQ];
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   scan_idx;
  logic            cmp_less, cmp_equal, cmp_greater;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[8*gi +: 8];
      assign b_arr[gi] = req_b[8*gi +: 8];
    end
  endgenerate

  eight_bit_comparator u_cmp (
    .a       (op_a_reg),
    .b       (op_b_reg),
    .less    (cmp_less),
    .equal   (cmp_equal),
    .greater (cmp_greater)
  );

  // Scan from rr_ptr in modular order; the first asserted valid wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && win_found && !reset)
      req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    cur_id_next      = cur_id_reg;
    op_a_next        = op_a_reg;
    op_b_next        = op_b_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_id_next      = rsp_id_reg;
    rsp_less_next    = rsp_less_reg;
    rsp_equal_next   = rsp_equal_reg;
    rsp_greater_next = rsp_greater_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          op_a_next   = a_arr[win_id];
          op_b_next   = b_arr[win_id];
          cur_id_next = win_id;
          rr_ptr_next = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
          state_next  = CMP;
        end
      end
      CMP: begin
        rsp_less_next    = cmp_less;
        rsp_equal_next   = cmp_equal;
        rsp_greater_next = cmp_greater;
        rsp_id_next      = cur_id_reg;
        rsp_valid_next   = 1'b1;
        state_next       = RESP;
      end
      RESP: begin
        // Response fields are left untouched so they hold until accepted.
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      cur_id_reg      <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_less_reg    <= 1'b0;
      rsp_equal_reg   <= 1'b0;
      rsp_greater_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      cur_id_reg      <= cur_id_next;
      op_a_reg        <= op_a_next;
      op_b_reg        <= op_b_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_less_reg    <= rsp_less_next;
      rsp_equal_reg   <= rsp_equal_next;
      rsp_greater_reg <= rsp_greater_next;
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_less    = rsp_less_reg;
  assign rsp_equal   = rsp_equal_reg;
  assign rsp_greater = rsp_greater_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed and randomized checks of comparator_arbiter with NUM_REQ = 4.

module tb_comparator_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int N_RAND  = 10000;
  localparam int LIMIT   = 80000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_less, rsp_equal, rsp_greater;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
  } txn_t;

  txn_t       exp_q [$];
  txn_t       t;
  logic [7:0] ra [NUM_REQ];
  logic [7:0] rb [NUM_REQ];
  logic [3:0] rv;
  logic [7:0] a_tab [5];
  logic [2:0] f_tab [5];
  int         mptr, w, raised, got, cyc;

  comparator_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_less    (rsp_less),
    .rsp_equal   (rsp_equal),
    .rsp_greater (rsp_greater),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flags;
    return {rsp_less, rsp_equal, rsp_greater};
  endfunction

  // One isolated request, rsp_ready held 1; expected flags given as {less,equal,greater}.
  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_f, input string tag);
    req_valid[id]     = 1'b1;
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    #1;
    chk({tag, "_ready"}, req_ready, 32'(1 << id));
    tick;
    req_valid[id] = 1'b0;
    #1;
    chk({tag, "_cmp_ready"}, req_ready, 0);
    chk({tag, "_cmp_valid"}, rsp_valid, 0);
    tick;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, id);
    chk({tag, "_flags"}, flags(), exp_f);
    tick;
    chk({tag, "_done_valid"}, rsp_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  function automatic int model_winner(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    a_tab[0] = 8'h00; f_tab[0] = 3'b100;
    a_tab[1] = 8'h10; f_tab[1] = 3'b100;
    a_tab[2] = 8'h30; f_tab[2] = 3'b001;
    a_tab[3] = 8'hA5; f_tab[3] = 3'b001;
    a_tab[4] = 8'h25; f_tab[4] = 3'b010;

    // Reset state
    tick;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b0;
    tick;

    single(2, 8'h5A, 8'h5A, 3'b010, "single_eq");
    single(0, 8'h80, 8'h7F, 3'b001, "msb_gt");
    single(1, 8'h00, 8'hFF, 3'b100, "zero_ff");
    single(3, 8'hFE, 8'hFF, 3'b100, "fe_ff");

    // Round robin: all four valid from reset
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*8 +: 8] = a_tab[i];
      req_b[i*8 +: 8] = 8'h25;
    end
    req_valid = 4'hF;
    #1;
    chk("rr_rst_ready", req_ready, 0);
    tick;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), req_ready, 32'(1 << (k % 4)));
      tick;
      req_a[(k % 4)*8 +: 8] = 8'h25;
      #1;
      chk($sformatf("rr_cmp_ready%0d", k), req_ready, 0);
      tick;
      chk($sformatf("rr_rsp_valid%0d", k), rsp_valid, 1);
      chk($sformatf("rr_rsp_id%0d", k), rsp_id, k % 4);
      chk($sformatf("rr_flags%0d", k), flags(), f_tab[k]);
      chk($sformatf("rr_rsp_ready%0d", k), req_ready, 0);
      tick;
    end

    // Backpressure with requests pending: requester 1 is next
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick;
    tick;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_valid%0d", c), rsp_valid, 1);
      chk($sformatf("bp_id%0d", c), rsp_id, 1);
      chk($sformatf("bp_flags%0d", c), flags(), 3'b010);
      chk($sformatf("bp_ready%0d", c), req_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    tick;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    tick;

    // Reset during CMP of requester 2's compare
    chk("mid_in_cmp_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick;
    chk("mid_rst_valid2", rsp_valid, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_flags", flags(), 0);
    req_valid = 4'b1010;
    reset = 1'b0;
    #1;
    chk("mid_first_grant", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    tick;
    chk("mid_rsp_valid", rsp_valid, 1);
    chk("mid_rsp_id", rsp_id, 1);
    tick;

    // Randomized scoreboard phase from a fresh reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rv = '0; mptr = 0; raised = 0; got = 0; cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) begin ra[i] = '0; rb[i] = '0; end
    while (got < N_RAND && cyc < LIMIT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rv[i] && raised < N_RAND && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = 8'($urandom);
          rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 8'($urandom);
          raised++;
        end
        req_a[i*8 +: 8] = ra[i];
        req_b[i*8 +: 8] = rb[i];
      end
      req_valid = rv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req_ready != 0) begin
        w = model_winner(rv, mptr);
        chk("rand_grant", req_ready, 32'(1 << w));
        t.id = w; t.a = ra[w]; t.b = rb[w];
        exp_q.push_back(t);
        rv[w] = 1'b0;
        mptr = (w + 1) % NUM_REQ;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra_rsp", exp_q.size(), 1);
        end else begin
          t = exp_q.pop_front();
          chk("rand_id", rsp_id, t.id);
          chk("rand_flags", flags(), {t.a < t.b, t.a == t.b, t.a > t.b});
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand_count", got, N_RAND);
    chk("rand_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
